// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: dispatch packet layout, CDB solution layout,
// ALU opcodes and the functional-unit FSM encoding.
package tomasulo_pkg;

   localparam int DATA_W  = 16;
   localparam int TAG_W   = 3;
   localparam int RD_W    = 4;
   localparam int OP_W    = 4;
   localparam int SHAMT_W = 4;

   localparam int PKT_W = TAG_W + OP_W + RD_W + 2 * DATA_W;
   localparam int SOL_W = RD_W + TAG_W + DATA_W;

   localparam int PKT_C_LSB   = 0;
   localparam int PKT_B_LSB   = 16;
   localparam int PKT_RD_LSB  = 32;
   localparam int PKT_OP_LSB  = 36;
   localparam int PKT_TAG_LSB = 40;

   localparam int SOL_DATA_LSB = 0;
   localparam int SOL_TAG_LSB  = 16;
   localparam int SOL_RD_LSB   = 19;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
   localparam logic [OP_W-1:0] OP_SLT = 4'b0100;
   localparam logic [OP_W-1:0] OP_MUL = 4'b0101;
   localparam logic [OP_W-1:0] OP_SHL = 4'b0110;
   localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
   localparam int              OP_MEM_BIT = 3;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [OP_W-1:0]   op;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] c;
   } alu_pkt_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WB
   } fu_state_e;

endpackage

// File: rtl/alu_functional_unit_queue.sv
// Small synchronous FIFO in front of the ALU; full is registered from the
// next occupancy so the dispatch stall is glitch-free.
module fu_queue #(
   parameter int W     = 43,
   parameter int DEPTH = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push on a full queue is refused even when a pop shares the edge.
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign empty     = (count == '0);
   assign dout      = mem[rd_ptr];
   assign count_nxt = count + CW'(do_push) - CW'(do_pop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/alu_functional_unit.sv
// Integer ALU functional unit: queues dispatched packets, executes one at a
// time with fixed latency and holds each result on the CDB until granted.
module alu_functional_unit
   import tomasulo_pkg::*;
#(
   parameter int Q_DEPTH = 2,
   parameter int MUL_LAT = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   input  logic [PKT_W-1:0] instruction_in,
   input  logic             cdb_ready,
   output logic [SOL_W-1:0] solution,
   output logic             store_cdb,
   output logic             alu_busy,
   output logic [1:0]       err_flags
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   alu_pkt_t          in_pkt;
   alu_pkt_t          head;
   alu_pkt_t          ex_q;
   alu_pkt_t          ex_n;
   fu_state_e         state_q;
   fu_state_e         state_n;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_n;
   logic [SOL_W-1:0]  sol_n;
   logic              store_n;
   logic [DATA_W-1:0] result;
   logic              legal;
   logic              q_full;
   logic              q_empty;
   logic              pop;

   assign in_pkt.tag = instruction_in[PKT_TAG_LSB +: TAG_W];
   assign in_pkt.op  = instruction_in[PKT_OP_LSB +: OP_W];
   assign in_pkt.rd  = instruction_in[PKT_RD_LSB +: RD_W];
   assign in_pkt.b   = instruction_in[PKT_B_LSB +: DATA_W];
   assign in_pkt.c   = instruction_in[PKT_C_LSB +: DATA_W];

   // Memory ops never enter the queue; they only raise the sticky flag.
   assign legal = !in_pkt.op[OP_MEM_BIT];

   fu_queue #(
      .W     (PKT_W),
      .DEPTH (Q_DEPTH)
   ) u_queue (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (run && legal),
      .pop     (pop),
      .din     (in_pkt),
      .dout    (head),
      .full    (q_full),
      .empty   (q_empty)
   );

   assign alu_busy = q_full;

   function automatic logic [CNT_W-1:0] lat_of(input logic [OP_W-1:0] op);
      return (op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
   endfunction

   always_comb begin
      result = '0;
      unique case (ex_q.op)
         OP_ADD:  result = ex_q.b + ex_q.c;
         OP_SUB:  result = ex_q.b - ex_q.c;
         OP_AND:  result = ex_q.b & ex_q.c;
         OP_OR:   result = ex_q.b | ex_q.c;
         OP_SLT:  result = {{(DATA_W-1){1'b0}},
                             $signed(ex_q.b) < $signed(ex_q.c)};
         OP_MUL:  result = ex_q.b * ex_q.c;
         OP_SHL:  result = ex_q.b << ex_q.c[SHAMT_W-1:0];
         OP_SHR:  result = ex_q.b >> ex_q.c[SHAMT_W-1:0];
         default: result = '0;
      endcase
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      ex_n    = ex_q;
      sol_n   = solution;
      store_n = store_cdb;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!q_empty) begin
               pop     = 1'b1;
               ex_n    = head;
               cnt_n   = lat_of(head.op);
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
               sol_n[SOL_RD_LSB +: RD_W]     = ex_q.rd;
               sol_n[SOL_TAG_LSB +: TAG_W]   = ex_q.tag;
               sol_n[SOL_DATA_LSB +: DATA_W] = result;
               store_n = 1'b1;
               state_n = S_WB;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
         S_WB: begin
            if (cdb_ready) begin
               store_n = 1'b0;
               if (!q_empty) begin
                  pop     = 1'b1;
                  ex_n    = head;
                  cnt_n   = lat_of(head.op);
                  state_n = S_EXEC;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ex_q      <= '0;
         solution  <= '0;
         store_cdb <= 1'b0;
         err_flags <= '0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         ex_q      <= ex_n;
         solution  <= sol_n;
         store_cdb <= store_n;
         err_flags <= err_flags | {run && !legal, run && legal && q_full};
      end
   end

endmodule

// File: tb/tb_alu_functional_unit.sv
// Scoreboard bench for alu_functional_unit: a reference model predicts each
// CDB broadcast, a monitor checks every granted transfer in order.
module tb_alu_functional_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        run;
   logic [42:0] instruction_in;
   logic        cdb_ready;
   logic [22:0] solution;
   logic        store_cdb;
   logic        alu_busy;
   logic [1:0]  err_flags;

   int checks = 0;
   int errors = 0;
   logic [22:0] exp_q[$];

   alu_functional_unit dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .run            (run),
      .instruction_in (instruction_in),
      .cdb_ready      (cdb_ready),
      .solution       (solution),
      .store_cdb      (store_cdb),
      .alu_busy       (alu_busy),
      .err_flags      (err_flags)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_alu(input int op, input int b,
                                           input int c);
      logic [31:0] r;
      int sb, sc;
      sb = (b >= 32768) ? b - 65536 : b;
      sc = (c >= 32768) ? c - 65536 : c;
      case (op)
         0: r = b + c;
         1: r = b - c;
         2: r = b & c;
         3: r = b | c;
         4: r = (sb < sc) ? 1 : 0;
         5: r = b * c;
         6: r = b * (2 ** (c % 16));
         7: r = b / (2 ** (c % 16));
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   always @(negedge clock) begin
      logic [22:0] e;
      if (reset_n && store_cdb && cdb_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cdb_unexpected: got %06h, required no broadcast",
                     solution);
         end else begin
            e = exp_q.pop_front();
            chk("cdb_result", 32'(solution), 32'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic dispatch(input logic [2:0] tag, input logic [3:0] op,
                           input logic [3:0] rd, input logic [15:0] b,
                           input logic [15:0] c, input bit accept);
      run = 1'b1;
      instruction_in = {tag, op, rd, b, c};
      if (accept && !op[3])
         exp_q.push_back({rd, tag, ref_alu(int'(op), int'(b), int'(c))});
      tick();
      run = 1'b0;
   endtask

   task automatic wait_store(input string name);
      int n = 0;
      while (!store_cdb && n < 20) begin
         tick();
         n++;
      end
      chk(name, 32'(store_cdb), 32'd1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      cdb_ready = 1'b1;
      while ((exp_q.size() != 0 || store_cdb) && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d results outstanding, required 0",
                  name, exp_q.size());
      end
   endtask

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 3))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      reset_n = 1'b0;
      run = 1'b0;
      cdb_ready = 1'b0;
      instruction_in = '0;
      repeat (2) tick();
      chk("rst_solution", 32'(solution), 32'd0);
      chk("rst_store", 32'(store_cdb), 32'd0);
      chk("rst_busy", 32'(alu_busy), 32'd0);
      chk("rst_err", 32'(err_flags), 32'd0);
      reset_n = 1'b1;
      cdb_ready = 1'b1;
      tick();

      // ADD latency: run at edge N, broadcast after N+2, gone after N+3
      dispatch(3'd3, 4'b0000, 4'd5, 16'h0007, 16'h0009, 1'b1);
      @(negedge clock);
      chk("add_store_n0", 32'(store_cdb), 32'd0);
      @(negedge clock);
      chk("add_store_n1", 32'(store_cdb), 32'd0);
      @(negedge clock);
      chk("add_store_n2", 32'(store_cdb), 32'd1);
      chk("add_solution", 32'(solution), 32'({4'd5, 3'd3, 16'h0010}));
      @(negedge clock);
      chk("add_store_n3", 32'(store_cdb), 32'd0);
      tick();

      // MUL wrap and latency
      dispatch(3'd1, 4'b0101, 4'd2, 16'h0100, 16'h0101, 1'b1);
      repeat (4) @(negedge clock);
      chk("mul_store_n3", 32'(store_cdb), 32'd0);
      @(negedge clock);
      chk("mul_store_n4", 32'(store_cdb), 32'd1);
      chk("mul_solution", 32'(solution), 32'({4'd2, 3'd1, 16'h0100}));
      tick();
      dispatch(3'd2, 4'b0001, 4'd7, 16'h0000, 16'h0001, 1'b1);
      dispatch(3'd4, 4'b0100, 4'd8, 16'hFFFF, 16'h0001, 1'b1);
      drain("drain_sub_slt");

      // Backpressure, full queue, dropped dispatch
      cdb_ready = 1'b0;
      dispatch(3'd0, 4'b0000, 4'd1, 16'h1111, 16'h2222, 1'b1);
      dispatch(3'd1, 4'b0011, 4'd2, 16'h0F00, 16'h00F0, 1'b1);
      dispatch(3'd2, 4'b0110, 4'd3, 16'h0001, 16'h0004, 1'b1);
      wait_store("bp_wait_store");
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_solution", 32'(solution), 32'(exp_q[0]));
         chk("bp_hold_store", 32'(store_cdb), 32'd1);
         tick();
      end
      chk("bp_busy", 32'(alu_busy), 32'd1);
      dispatch(3'd3, 4'b0000, 4'd4, 16'h0005, 16'h0005, 1'b0);
      @(negedge clock);
      chk("bp_err_drop", 32'(err_flags[0]), 32'd1);
      tick();
      drain("drain_bp");
      chk("bp_busy_clear", 32'(alu_busy), 32'd0);

      // Push on full queue during the completion edge is dropped
      cdb_ready = 1'b0;
      dispatch(3'd5, 4'b0111, 4'd9, 16'h8000, 16'h000F, 1'b1);
      dispatch(3'd6, 4'b0010, 4'd10, 16'hF0F0, 16'hFF00, 1'b1);
      dispatch(3'd7, 4'b0001, 4'd11, 16'h0003, 16'h0005, 1'b1);
      wait_store("sim_wait_store");
      cdb_ready = 1'b1;
      dispatch(3'd0, 4'b0000, 4'd12, 16'hDEAD, 16'h0001, 1'b0);
      dispatch(3'd1, 4'b0000, 4'd13, 16'h1234, 16'h4321, 1'b1);
      drain("drain_sim");

      // Illegal opcode leaves the queue untouched
      cdb_ready = 1'b0;
      dispatch(3'd2, 4'b0000, 4'd1, 16'h0001, 16'h0001, 1'b1);
      dispatch(3'd3, 4'b0000, 4'd2, 16'h0002, 16'h0002, 1'b1);
      dispatch(3'd4, 4'b1001, 4'd3, 16'h0003, 16'h0003, 1'b1);
      @(negedge clock);
      chk("ill_busy", 32'(alu_busy), 32'd0);
      chk("ill_err", 32'(err_flags), 32'd3);
      tick();
      dispatch(3'd5, 4'b0000, 4'd4, 16'h0004, 16'h0004, 1'b1);
      chk("ill_busy_full", 32'(alu_busy), 32'd1);
      drain("drain_ill");

      // Asynchronous reset in the middle of a MUL
      dispatch(3'd6, 4'b0101, 4'd5, 16'h0033, 16'h0044, 1'b1);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_solution", 32'(solution), 32'd0);
      chk("arst_store", 32'(store_cdb), 32'd0);
      chk("arst_busy", 32'(alu_busy), 32'd0);
      chk("arst_err", 32'(err_flags), 32'd0);
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      repeat (8) tick();
      chk("arst_no_stale", 32'(store_cdb), 32'd0);
      dispatch(3'd7, 4'b0000, 4'd6, 16'h0100, 16'h0023, 1'b1);
      drain("drain_arst");

      // Random traffic with random bus grants
      for (int i = 0; i < 400; i++) begin
         logic [3:0] op;
         cdb_ready = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 8) == 8) ? 4'(8 + $urandom_range(0, 7))
                                          : 4'($urandom_range(0, 7));
         if (!alu_busy && $urandom_range(0, 1) == 1)
            dispatch(3'($urandom), op, 4'($urandom), pick16(), pick16(),
                     1'b1);
         else
            tick();
      end
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_functional_unit.md
Name: alu_functional_unit

Overview:
Integer execution unit directly downstream of the reservation station. It consumes dispatched ALU instructions (run + 43-bit packet), executes them with fixed per-opcode latency, and broadcasts {rd, tag, result} on the common data bus. The reservation station uses that broadcast to wake dependents and free the slot. A 2-entry input queue absorbs dispatches that arrive while a result is still executing or waiting for the bus.

Parameters:
DATA_W, 16, operand/result width
TAG_W, 3, reservation-station slot tag width
Q_DEPTH, 2, input queue entries (power of two)
MUL_LAT, 3, execute cycles for MUL (all other ops: 1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
run  input  1  dispatch strobe; packet valid this cycle
instruction_in  input  43  {tag[42:40], opcode[39:36], rd[35:32], b[31:16], c[15:0]}
cdb_ready  input  1  bus grant; transfer occurs on an edge with store_cdb=1 and cdb_ready=1
solution  output  23  {rd[22:19], tag[18:16], data[15:0]}
store_cdb  output  1  solution valid on the bus
alu_busy  output  1  queue full; station must not dispatch
err_flags  output  2  sticky: [0] dispatch dropped (queue full), [1] illegal opcode

Behaviour:
- Reset (async, reset_n=0): queue empty, FSM IDLE, solution=0, store_cdb=0, alu_busy=0, err_flags=0. Reset mid-execution discards all in-flight work; no partial broadcast.
- Enqueue: on an edge with run=1 and queue not full, push the packet. If run=1 and the queue is full, drop the packet and set err_flags[0]. alu_busy = (count==Q_DEPTH), registered from next count.
- Opcodes: 0000 ADD b+c; 0001 SUB b-c; 0010 AND; 0011 OR; 0100 SLT (signed b<c gives 1, else 0); 0101 MUL (low 16 bits of b*c); 0110 SHL b<<c[3:0]; 0111 SHR logical b>>c[3:0]. Opcode[3]=1 (memory op) is not executed: dropped at enqueue, sets err_flags[1], no broadcast. All arithmetic wraps modulo 2^16.
- FSM:
  - IDLE: queue non-empty -> pop head into exec regs, go EXEC, cnt=lat-1.
  - EXEC: cnt==0 -> latch solution={rd,tag,result}, set store_cdb=1, go WB; else cnt-1.
  - WB: on edge with cdb_ready=1, the transfer completes. If the queue is non-empty, pop the head into EXEC on that same edge and clear store_cdb; otherwise clear store_cdb and go IDLE. While cdb_ready=0, solution and store_cdb hold unchanged.
- Latency: run sampled at edge N into an empty idle unit -> store_cdb=1 after edge N+2 (1-cycle op) or N+MUL_LAT+1 (MUL). Non-pipelined.
- Throughput: one result per 2 cycles for 1-cycle ops with cdb_ready held high.
- Simultaneous push and pop on the same edge: legal; count is unchanged, including when full. The full check uses the pre-edge count, so a push on a full queue is dropped even if a pop occurs on that edge.
- Queue pointers wrap modulo Q_DEPTH. Order is strict FIFO.

Decomposition:
- Package tomasulo_pkg: opcode localparams (OP_ADD..OP_SHR, OP_MEM_BIT=3), packet field offsets, TAG_W/DATA_W, CDB solution field offsets, shared with reserve_station and memory unit.
- Sub-module fu_queue: parameterised synchronous FIFO (push, pop, full, empty, async active-low reset).
- ALU result function is combinational logic inside alu_functional_unit.

Test Plan:
- ADD: reset, cdb_ready=1, run with {tag=3, op=0000, rd=5, b=0x0007, c=0x0009} at edge N -> store_cdb=1 after N+2, solution={5,3,0x0010}, store_cdb=0 after N+3.
- MUL and wrap: b=0x0100, c=0x0101 -> solution.data=0x0100 (low 16 bits of 0x10100), broadcast after N+MUL_LAT+1. SUB 0x0000-0x0001 -> 0xFFFF. SLT 0xFFFF,0x0001 -> 1.
- Backpressure: cdb_ready=0 while a result is pending -> solution and store_cdb held for 5 cycles. Dispatch 2 more -> alu_busy=1. A 4th run -> err_flags[0]=1. Raise cdb_ready -> the remaining two results broadcast in FIFO order.
- Simultaneous push and pop with a full queue: run on the completion edge is dropped; run one cycle later is accepted.
- Illegal op: opcode 1001 -> no broadcast, err_flags[1]=1, queue count unchanged.
- Async reset asserted mid-MUL (between edges) -> outputs 0 immediately. After release, no stale broadcast occurs and a new ADD completes normally.
